// File: rtl/complex_dot_result_collector_pkg.sv
// Shared constants and FSM encoding for the complex dot-product result collector.
// Complex element layout: real half in the upper bits, imag half in the lower bits,
// both two's complement.
package complex_dot_result_collector_pkg;

  localparam int unsigned ELEMENT_WIDTH  = 64;
  localparam int unsigned NO_OF_UNITS    = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam int unsigned REAL_MSB = 63;
  localparam int unsigned REAL_LSB = 32;
  localparam int unsigned IMAG_MSB = 31;
  localparam int unsigned IMAG_LSB = 0;
  localparam int unsigned HALF_W   = IMAG_MSB - IMAG_LSB + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/complex_packed_fifo.sv
// Synchronous FIFO for packed result words plus a per-entry "last" tag.
// A push into a full FIFO succeeds only when a pop frees the slot in the same cycle;
// otherwise the word is dropped and drop_c reports it.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push_i/push_data_i/push_last_i   write side
//   pop_i               consumer takes head (ignored when empty)
//   head_data_o/head_last_o          head entry, zero when empty
//   valid_o             FIFO non-empty (registered)
//   not_full_o          count < DEPTH (registered)
//   drop_c              combinational: push lost this cycle
module complex_packed_fifo #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o,
  output logic              valid_o,
  output logic              not_full_o,
  output logic              drop_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0]  last_mem_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              valid_q, not_full_q;
  logic              full_c, pop_en_c, push_en_c;

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    full_c    = (count_q == CW'(DEPTH));
    pop_en_c  = pop_i && valid_q;
    push_en_c = push_i && (!full_c || pop_en_c);
    drop_c    = push_i && full_c && !pop_en_c;
    wr_ptr_d  = push_en_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_en_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push_en_c) - CW'(pop_en_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      not_full_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      not_full_q <= (count_d < CW'(DEPTH));
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_en_c) begin
      data_mem_q[wr_ptr_q] <= push_data_i;
      last_mem_q[wr_ptr_q] <= push_last_i;
    end
  end

  assign head_data_o = valid_q ? data_mem_q[rd_ptr_q] : '0;
  assign head_last_o = valid_q && last_mem_q[rd_ptr_q];
  assign valid_o     = valid_q;
  assign not_full_o  = not_full_q;

endmodule

// File: rtl/complex_dot_result_collector.sv
// Collects scalar complex dot-product results and packs no_of_units of them (lane 0 first)
// into one wide word, buffered in a small FIFO for the next stage.
// Build option: define COLLECTOR_CONJ_EN to store the conjugate of each result
// (imag half negated); otherwise results are stored unmodified.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, total               job start pulse and number of results in the job
//   dot_product_in, finish     incoming result and its valid pulse
//   collector_ready            FIFO has room (registered)
//   packed_out/valid/ready/last  packed word handshake to the consumer
//   done                       one-cycle pulse after the final word is popped
//   overflow                   sticky: a completed word was dropped on a full FIFO
module complex_dot_result_collector
  import complex_dot_result_collector_pkg::*;
#(
  parameter int unsigned element_width = ELEMENT_WIDTH,
  parameter int unsigned no_of_units   = NO_OF_UNITS,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic [element_width-1:0]             dot_product_in,
  input  logic                                 finish,
  output logic                                 collector_ready,
  output logic [element_width*no_of_units-1:0] packed_out,
  output logic                                 packed_valid,
  input  logic                                 packed_ready,
  output logic                                 packed_last,
  output logic                                 done,
  output logic                                 overflow
);

  localparam int unsigned PACKED_W = element_width * no_of_units;
  localparam int unsigned LANE_W   = (no_of_units > 1) ? $clog2(no_of_units) : 1;

  state_e                 state_q, state_d;
  logic [31:0]            total_q, total_d;
  logic [31:0]            res_cnt_q, res_cnt_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [PACKED_W-1:0]    pack_q, pack_d;
  logic                   done_q, done_d;
  logic                   overflow_q;

  logic [element_width-1:0] elem_c;
  logic [PACKED_W-1:0]      word_c;
  logic                     push_c, push_last_c, last_res_c, pop_c, drop_c;

  // Value actually stored for the incoming result.
  always_comb begin
    elem_c = dot_product_in;
`ifdef COLLECTOR_CONJ_EN
    // Two's-complement negate; the most negative value maps onto itself.
    elem_c[IMAG_MSB:IMAG_LSB] = (~dot_product_in[IMAG_MSB:IMAG_LSB]) + HALF_W'(1);
`endif
  end

  assign pop_c = packed_valid && packed_ready;

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    res_cnt_d   = res_cnt_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    push_c      = 1'b0;
    push_last_c = 1'b0;
    last_res_c  = (res_cnt_q == total_q - 32'd1);
    word_c      = pack_q;
    word_c[lane_q*element_width +: element_width] = elem_c;

    case (state_q)
      IDLE: begin
        if (start) begin
          total_d   = total;
          res_cnt_d = '0;
          lane_d    = '0;
          pack_d    = '0;
          state_d   = (total == 32'd0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (finish) begin
          res_cnt_d = res_cnt_q + 32'd1;
          // The lane being written is part of the word pushed this cycle.
          if (lane_q == LANE_W'(no_of_units - 1) || last_res_c) begin
            push_c      = 1'b1;
            push_last_c = last_res_c;
            pack_d      = '0;
            lane_d      = '0;
            if (last_res_c) state_d = DRAIN;
          end else begin
            pack_d = word_c;
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      DRAIN: begin
        if (pop_c && packed_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      total_q    <= '0;
      res_cnt_q  <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      res_cnt_q  <= res_cnt_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      done_q     <= done_d;
      overflow_q <= overflow_q || drop_c;
    end
  end

  complex_packed_fifo #(
    .DATA_W (PACKED_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_c),
    .push_data_i (word_c),
    .push_last_i (push_last_c),
    .pop_i       (pop_c),
    .head_data_o (packed_out),
    .head_last_o (packed_last),
    .valid_o     (packed_valid),
    .not_full_o  (collector_ready),
    .drop_c      (drop_c)
  );

  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_complex_dot_result_collector.sv
module tb_complex_dot_result_collector;

  localparam int EW = 64;
  localparam int NU = 8;
  localparam int PW = EW * NU;
`ifdef COLLECTOR_CONJ_EN
  localparam bit CONJ = 1'b1;
`else
  localparam bit CONJ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, finish, packed_ready;
  logic [31:0]   total;
  logic [EW-1:0] dot_product_in;
  logic          collector_ready, packed_valid, packed_last, done, overflow;
  logic [PW-1:0] packed_out;

  int vectors = 0;
  int miscompares = 0;

  complex_dot_result_collector dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .total           (total),
    .dot_product_in  (dot_product_in),
    .finish          (finish),
    .collector_ready (collector_ready),
    .packed_out      (packed_out),
    .packed_valid    (packed_valid),
    .packed_ready    (packed_ready),
    .packed_last     (packed_last),
    .done            (done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(int re, int im);
    return {re[31:0], im[31:0]};
  endfunction

  // Expected packed word: n consecutive results {k,-k} starting at k=first, lane 0 first.
  // Conjugating {k,-k} yields {k,k}.
  function automatic logic [PW-1:0] exp_word(int first, int n);
    logic [PW-1:0] w;
    w = '0;
    for (int i = 0; i < n; i++)
      w[i*EW +: EW] = mk(first + i, CONJ ? (first + i) : -(first + i));
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [EW-1:0] d);
    dot_product_in = d;
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  task automatic start_job(input int t);
    total = t;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0; packed_ready = 1'b0;
    total = '0; dot_product_in = '0;
    step(); step();
    reset = 1'b0;
    vectors++; if (collector_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b exp 1", collector_ready); end
    vectors++; if (packed_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b exp 0", packed_valid); end
    vectors++; if (packed_out !== '0) begin miscompares++; $display("FAIL rst_out: got %h exp 0", packed_out); end
    vectors++; if (packed_last !== 1'b0) begin miscompares++; $display("FAIL rst_last: got %b exp 0", packed_last); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b exp 0", done); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b exp 0", overflow); end
  endtask

  task automatic test_single_word();
    packed_ready = 1'b1;
    start_job(8);
    for (int k = 1; k <= 8; k++) begin
      pulse(mk(k, -k));
      if (k == 7) begin
        vectors++; if (packed_valid !== 1'b0) begin miscompares++; $display("FAIL t1_early_valid: got %b exp 0", packed_valid); end
      end
    end
    vectors++; if (packed_valid !== 1'b1) begin miscompares++; $display("FAIL t1_valid: got %b exp 1", packed_valid); end
    vectors++; if (packed_out !== exp_word(1, 8)) begin miscompares++; $display("FAIL t1_word: got %h exp %h", packed_out, exp_word(1, 8)); end
    vectors++; if (packed_last !== 1'b1) begin miscompares++; $display("FAIL t1_last: got %b exp 1", packed_last); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL t1_done_early: got %b exp 0", done); end
    step();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL t1_done: got %b exp 1", done); end
    vectors++; if (packed_valid !== 1'b0) begin miscompares++; $display("FAIL t1_empty: got %b exp 0", packed_valid); end
    step();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL t1_done_pulse: got %b exp 0", done); end
    packed_ready = 1'b0;
  endtask

  task automatic test_two_words();
    packed_ready = 1'b0;
    start_job(11);
    for (int k = 1; k <= 8; k++) pulse(mk(k, -k));
    vectors++; if (packed_out !== exp_word(1, 8)) begin miscompares++; $display("FAIL t2_word1: got %h exp %h", packed_out, exp_word(1, 8)); end
    vectors++; if (packed_last !== 1'b0) begin miscompares++; $display("FAIL t2_last1: got %b exp 0", packed_last); end
    for (int k = 9; k <= 11; k++) pulse(mk(k, -k));
    vectors++; if (packed_out !== exp_word(1, 8)) begin miscompares++; $display("FAIL t2_word1_hold: got %h exp %h", packed_out, exp_word(1, 8)); end
    packed_ready = 1'b1;
    step();
    vectors++; if (packed_out !== exp_word(9, 3)) begin miscompares++; $display("FAIL t2_word2: got %h exp %h", packed_out, exp_word(9, 3)); end
    vectors++; if (packed_last !== 1'b1) begin miscompares++; $display("FAIL t2_last2: got %b exp 1", packed_last); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL t2_done_early: got %b exp 0", done); end
    step();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL t2_done: got %b exp 1", done); end
    packed_ready = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    packed_ready = 1'b0;
    start_job(40);
    for (int k = 1; k <= 32; k++) begin
      pulse(mk(k, -k));
      if (k == 31) begin
        vectors++; if (collector_ready !== 1'b1) begin miscompares++; $display("FAIL t3_ready_3w: got %b exp 1", collector_ready); end
      end
    end
    vectors++; if (collector_ready !== 1'b0) begin miscompares++; $display("FAIL t3_ready_4w: got %b exp 0", collector_ready); end
    for (int k = 33; k <= 39; k++) pulse(mk(k, -k));
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t3_ovf_early: got %b exp 0", overflow); end
    pulse(mk(40, -40));
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t3_ovf: got %b exp 1", overflow); end
    packed_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      vectors++; if (packed_out !== exp_word(1 + 8*w, 8)) begin miscompares++; $display("FAIL t3_word%0d: got %h exp %h", w, packed_out, exp_word(1 + 8*w, 8)); end
      vectors++; if (packed_last !== 1'b0) begin miscompares++; $display("FAIL t3_last%0d: got %b exp 0", w, packed_last); end
      step();
    end
    vectors++; if (packed_valid !== 1'b0) begin miscompares++; $display("FAIL t3_drained: got %b exp 0", packed_valid); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t3_ovf_sticky: got %b exp 1", overflow); end
    packed_ready = 1'b0;
    do_reset();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t3_ovf_clear: got %b exp 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    packed_ready = 1'b0;
    start_job(40);
    for (int k = 1; k <= 39; k++) pulse(mk(k, -k));
    packed_ready = 1'b1;
    pulse(mk(40, -40));
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t4_ovf: got %b exp 0", overflow); end
    vectors++; if (collector_ready !== 1'b0) begin miscompares++; $display("FAIL t4_still_full: got %b exp 0", collector_ready); end
    for (int w = 1; w <= 4; w++) begin
      vectors++; if (packed_out !== exp_word(1 + 8*w, 8)) begin miscompares++; $display("FAIL t4_word%0d: got %h exp %h", w, packed_out, exp_word(1 + 8*w, 8)); end
      vectors++; if (packed_last !== (w == 4)) begin miscompares++; $display("FAIL t4_last%0d: got %b exp %b", w, packed_last, (w == 4)); end
      step();
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL t4_done: got %b exp 1", done); end
    vectors++; if (packed_valid !== 1'b0) begin miscompares++; $display("FAIL t4_empty: got %b exp 0", packed_valid); end
    packed_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_job();
    packed_ready = 1'b0;
    start_job(8);
    pulse(mk(100, 1));
    pulse(mk(101, 2));
    pulse(mk(102, 3));
    do_reset();
    vectors++; if (packed_valid !== 1'b0) begin miscompares++; $display("FAIL t5_valid: got %b exp 0", packed_valid); end
    vectors++; if (collector_ready !== 1'b1) begin miscompares++; $display("FAIL t5_ready: got %b exp 1", collector_ready); end
    start_job(0);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL t5_done_zero: got %b exp 1", done); end
    vectors++; if (packed_valid !== 1'b0) begin miscompares++; $display("FAIL t5_no_word: got %b exp 0", packed_valid); end
    step();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL t5_done_pulse: got %b exp 0", done); end
    start_job(1);
    pulse(mk(7, -7));
    vectors++; if (packed_out !== exp_word(7, 1)) begin miscompares++; $display("FAIL t5_single: got %h exp %h", packed_out, exp_word(7, 1)); end
    vectors++; if (packed_last !== 1'b1) begin miscompares++; $display("FAIL t5_single_last: got %b exp 1", packed_last); end
    packed_ready = 1'b1;
    step();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL t5_single_done: got %b exp 1", done); end
    packed_ready = 1'b0;
    step();
  endtask

  task automatic test_conj();
    logic [PW-1:0] w;
    w = '0;
    w[63:0]   = CONJ ? {32'd5, 32'hFFFF_FFF9} : {32'd5, 32'd7};
    w[127:64] = {32'd3, 32'h8000_0000};
    packed_ready = 1'b0;
    start_job(2);
    pulse({32'd5, 32'd7});
    pulse({32'd3, 32'h8000_0000});
    vectors++; if (packed_out !== w) begin miscompares++; $display("FAIL t6_conj: got %h exp %h", packed_out, w); end
    vectors++; if (packed_last !== 1'b1) begin miscompares++; $display("FAIL t6_last: got %b exp 1", packed_last); end
    packed_ready = 1'b1;
    step();
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL t6_done: got %b exp 1", done); end
    packed_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_words();
    test_backpressure();
    test_full_push_pop();
    test_reset_mid_job();
    test_conj();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
